// File: rtl/vec_alu_pkg.sv
// Shared types for the vector lane ALU sequencer: opcodes, compare codes,
// ALU result-select constants and the opcode decode function.
package vec_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_FADD = 4'd2,
    OP_FSUB = 4'd3,
    OP_MUL  = 4'd4,
    OP_FMUL = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_CMP  = 4'd10
  } vop_e;

  typedef enum logic [3:0] {
    CMP_EQ = 4'd0,
    CMP_NE = 4'd1,
    CMP_LT = 4'd2,
    CMP_GE = 4'd3
  } cmp_e;

  localparam logic [2:0] OUT_ADDSUB  = 3'b000;
  localparam logic [2:0] OUT_FADDSUB = 3'b001;
  localparam logic [2:0] OUT_MUL     = 3'b010;
  localparam logic [2:0] OUT_FMUL    = 3'b011;
  localparam logic [2:0] OUT_BITWISE = 3'b100;

  typedef struct packed {
    logic [2:0] out_ctrl;
    logic       addsub;
    logic [1:0] bitwise;
    logic       is_cmp;
    logic       legal;
  } dec_t;

  function automatic dec_t decode_op(input logic [3:0] op);
    dec_t d;
    // NOTE: every field gets a default before the case, so no path can leave
    // a field unassigned and infer a latch when this is used combinationally.
    d       = '0;
    d.legal = 1'b1;
    case (op)
      OP_ADD:  d.out_ctrl = OUT_ADDSUB;
      OP_SUB:  begin d.out_ctrl = OUT_ADDSUB;  d.addsub = 1'b1; end
      OP_FADD: d.out_ctrl = OUT_FADDSUB;
      OP_FSUB: begin d.out_ctrl = OUT_FADDSUB; d.addsub = 1'b1; end
      OP_MUL:  d.out_ctrl = OUT_MUL;
      OP_FMUL: d.out_ctrl = OUT_FMUL;
      // op-6 modulo 4 equals op+2 on the low two bits (AND=0 .. NOT=3)
      OP_AND, OP_OR, OP_XOR, OP_NOT: begin
        d.out_ctrl = OUT_BITWISE;
        d.bitwise  = op[1:0] + 2'd2;
      end
      OP_CMP:  d.is_cmp = 1'b1;
      default: d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/vec_alu_decode.sv
// Combinational opcode decode feeding the ALU control outputs.
module vec_alu_decode
  import vec_alu_pkg::*;
(
  input  logic [3:0] i_op,
  output dec_t       o_dec
);

  assign o_dec = decode_op(i_op);

endmodule

// File: rtl/vec_alu_sequencer.sv
// Per-instruction sequencer: walks elements 0..vl-1 through a
// read / execute / write pipeline around the combinational lane ALU.
module vec_alu_sequencer
  import vec_alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int VLMAX = 32,
  parameter  int NVREG = 32,
  localparam int EW    = $clog2(VLMAX),
  localparam int VLW   = EW + 1,
  localparam int RW    = $clog2(NVREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_val,
  output logic              req_rdy,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_cmp,
  input  logic [RW-1:0]     req_vd,
  input  logic [RW-1:0]     req_vs1,
  input  logic [RW-1:0]     req_vs2,
  input  logic              req_use_scalar,
  input  logic [WIDTH-1:0]  req_scalar,
  input  logic [VLW-1:0]    req_vl,
  input  logic              req_masked,
  input  logic [VLMAX-1:0]  req_mask,
  output logic              rf_rd_en,
  output logic [RW+EW-1:0]  rf_rd_addr_a,
  output logic [RW+EW-1:0]  rf_rd_addr_b,
  input  logic [WIDTH-1:0]  rf_rd_data_a,
  input  logic [WIDTH-1:0]  rf_rd_data_b,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [WIDTH-1:0]  alu_c,
  output logic              alu_addsub,
  output logic              alu_mux,
  output logic [2:0]        alu_out_ctrl,
  output logic [1:0]        alu_bitwise,
  output logic [3:0]        alu_comp,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_predicate,
  output logic              rf_wr_en,
  output logic [RW+EW-1:0]  rf_wr_addr,
  output logic [WIDTH-1:0]  rf_wr_data,
  output logic              mask_wr_en,
  output logic [EW-1:0]     mask_wr_idx,
  output logic              mask_wr_data,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_e;

  state_e             r_state;
  logic [3:0]         r_op;
  logic [3:0]         r_cmp;
  logic [RW-1:0]      r_vd;
  logic [RW-1:0]      r_vs1;
  logic [RW-1:0]      r_vs2;
  logic               r_use_scalar;
  logic [WIDTH-1:0]   r_scalar;
  logic [VLW-1:0]     r_vl;
  logic               r_masked;
  logic [VLMAX-1:0]   r_mask;
  logic [EW-1:0]      r_idx;

  logic               r_s1_val;
  logic [EW-1:0]      r_s1_idx;
  logic               r_s2_val;
  logic               r_s2_rf_we;
  logic               r_s2_mask_we;
  logic [EW-1:0]      r_s2_idx;
  logic [WIDTH-1:0]   r_s2_result;
  logic               r_s2_pred;

  logic               w_accept;
  logic [VLW-1:0]     w_vl_eff;
  logic               w_last_issue;
  logic               w_elem_en;
  logic               w_s1_rf_we;
  logic               w_s1_mask_we;
  dec_t               w_dec;

  vec_alu_decode u_decode (
    .i_op  (r_op),
    .o_dec (w_dec)
  );

  assign w_accept     = req_val & req_rdy;
  assign w_vl_eff     = (req_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : req_vl;
  assign w_last_issue = ({1'b0, r_idx} == (r_vl - VLW'(1)));

  // Masked-off elements still flow through the pipe; only their writes drop.
  assign w_elem_en    = ~r_masked | r_mask[r_s1_idx];
  assign w_s1_rf_we   = r_s1_val & w_dec.legal & ~w_dec.is_cmp & w_elem_en;
  assign w_s1_mask_we = r_s1_val & w_dec.is_cmp & w_elem_en;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_op         <= '0;
      r_cmp        <= '0;
      r_vd         <= '0;
      r_vs1        <= '0;
      r_vs2        <= '0;
      r_use_scalar <= 1'b0;
      r_scalar     <= '0;
      r_vl         <= '0;
      r_masked     <= 1'b0;
      r_mask       <= '0;
      r_idx        <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_op         <= req_op;
            r_cmp        <= req_cmp;
            r_vd         <= req_vd;
            r_vs1        <= req_vs1;
            r_vs2        <= req_vs2;
            r_use_scalar <= req_use_scalar;
            r_scalar     <= req_scalar;
            r_vl         <= w_vl_eff;
            r_masked     <= req_masked;
            r_mask       <= req_mask;
            r_idx        <= '0;
            r_state      <= (w_vl_eff == '0) ? S_DONE : S_ISSUE;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_idx <= r_idx + 1'b1;
          if (w_last_issue) r_state <= S_DRAIN;
        end
        // S2 is loaded from S1, so once S1 is empty both stages are empty
        // after this edge and done lines up with the cycle after the last write.
        S_DRAIN: if (!r_s1_val) r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_val     <= 1'b0;
      r_s1_idx     <= '0;
      r_s2_val     <= 1'b0;
      r_s2_rf_we   <= 1'b0;
      r_s2_mask_we <= 1'b0;
      r_s2_idx     <= '0;
      r_s2_result  <= '0;
      r_s2_pred    <= 1'b0;
    end else begin
      r_s1_val     <= rf_rd_en;
      r_s1_idx     <= r_idx;
      r_s2_val     <= r_s1_val;
      r_s2_rf_we   <= w_s1_rf_we;
      r_s2_mask_we <= w_s1_mask_we;
      r_s2_idx     <= r_s1_idx;
      r_s2_result  <= alu_result;
      r_s2_pred    <= alu_predicate;
    end
  end

  assign req_rdy      = (r_state == S_IDLE) | (r_state == S_DONE);
  assign done         = (r_state == S_DONE);

  assign rf_rd_en     = (r_state == S_ISSUE);
  assign rf_rd_addr_a = rf_rd_en ? {r_vs1, r_idx} : '0;
  assign rf_rd_addr_b = rf_rd_en ? {r_vs2, r_idx} : '0;

  assign alu_a        = r_s1_val ? rf_rd_data_a : '0;
  assign alu_b        = r_s1_val ? rf_rd_data_b : '0;
  assign alu_c        = r_s1_val ? r_scalar     : '0;
  assign alu_addsub   = r_s1_val & w_dec.addsub;
  assign alu_mux      = r_s1_val & r_use_scalar;
  assign alu_out_ctrl = r_s1_val ? w_dec.out_ctrl : '0;
  assign alu_bitwise  = r_s1_val ? w_dec.bitwise  : '0;
  assign alu_comp     = (r_s1_val & w_dec.is_cmp) ? r_cmp : '0;

  assign rf_wr_en     = r_s2_val & r_s2_rf_we;
  assign rf_wr_addr   = rf_wr_en ? {r_vd, r_s2_idx} : '0;
  assign rf_wr_data   = rf_wr_en ? r_s2_result : '0;
  assign mask_wr_en   = r_s2_val & r_s2_mask_we;
  assign mask_wr_idx  = mask_wr_en ? r_s2_idx : '0;
  assign mask_wr_data = mask_wr_en & r_s2_pred;

endmodule

// File: tb/tb_vec_alu_sequencer.sv
// Directed bench for vec_alu_sequencer with a register-file model and a
// stand-in lane ALU driven purely by the sequencer's control outputs.
module tb_vec_alu_sequencer;
  import vec_alu_pkg::*;

  localparam int WIDTH = 32;
  localparam int VLMAX = 32;
  localparam int NVREG = 32;
  localparam int EW    = 5;
  localparam int VLW   = 6;
  localparam int RW    = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_val;
  logic              req_rdy;
  logic [3:0]        req_op;
  logic [3:0]        req_cmp;
  logic [RW-1:0]     req_vd, req_vs1, req_vs2;
  logic              req_use_scalar;
  logic [WIDTH-1:0]  req_scalar;
  logic [VLW-1:0]    req_vl;
  logic              req_masked;
  logic [VLMAX-1:0]  req_mask;
  logic              rf_rd_en;
  logic [RW+EW-1:0]  rf_rd_addr_a, rf_rd_addr_b;
  logic [WIDTH-1:0]  rf_rd_data_a = '0;
  logic [WIDTH-1:0]  rf_rd_data_b = '0;
  logic [WIDTH-1:0]  alu_a, alu_b, alu_c;
  logic              alu_addsub, alu_mux;
  logic [2:0]        alu_out_ctrl;
  logic [1:0]        alu_bitwise;
  logic [3:0]        alu_comp;
  logic [WIDTH-1:0]  alu_result;
  logic              alu_predicate;
  logic              rf_wr_en;
  logic [RW+EW-1:0]  rf_wr_addr;
  logic [WIDTH-1:0]  rf_wr_data;
  logic              mask_wr_en;
  logic [EW-1:0]     mask_wr_idx;
  logic              mask_wr_data;
  logic              done;

  always #5 clk = ~clk;

  vec_alu_sequencer #(.WIDTH(WIDTH), .VLMAX(VLMAX), .NVREG(NVREG)) dut (
    .clk(clk), .reset(reset),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_cmp(req_cmp),
    .req_vd(req_vd), .req_vs1(req_vs1), .req_vs2(req_vs2),
    .req_use_scalar(req_use_scalar), .req_scalar(req_scalar), .req_vl(req_vl),
    .req_masked(req_masked), .req_mask(req_mask),
    .rf_rd_en(rf_rd_en), .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_addr_b(rf_rd_addr_b),
    .rf_rd_data_a(rf_rd_data_a), .rf_rd_data_b(rf_rd_data_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_addsub(alu_addsub),
    .alu_mux(alu_mux), .alu_out_ctrl(alu_out_ctrl), .alu_bitwise(alu_bitwise),
    .alu_comp(alu_comp), .alu_result(alu_result), .alu_predicate(alu_predicate),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .mask_wr_en(mask_wr_en), .mask_wr_idx(mask_wr_idx), .mask_wr_data(mask_wr_data),
    .done(done)
  );

  // Fixed register-file contents: vreg 1 = {1,2,3..}, vreg 2 = {10,20,30..},
  // vreg 3 = {7,5,3..}, vreg 4 = {3,9,8,8..}, vreg 5 = all 5, others r*256+e.
  function automatic logic [WIDTH-1:0] init_val(input int r, input int e);
    case (r)
      1:       return WIDTH'(e + 1);
      2:       return WIDTH'(10 * (e + 1));
      3:       return WIDTH'(7 - 2 * e);
      4:       return (e == 0) ? 32'd3 : (e == 1) ? 32'd9 : 32'd8;
      5:       return 32'd5;
      default: return WIDTH'(r * 256 + e);
    endcase
  endfunction

  always @(posedge clk) begin
    if (rf_rd_en) begin
      rf_rd_data_a <= init_val(int'(rf_rd_addr_a[RW+EW-1:EW]), int'(rf_rd_addr_a[EW-1:0]));
      rf_rd_data_b <= init_val(int'(rf_rd_addr_b[RW+EW-1:EW]), int'(rf_rd_addr_b[EW-1:0]));
    end
  end

  logic [WIDTH-1:0] stub_b;
  always_comb begin
    stub_b        = alu_mux ? alu_c : alu_b;
    alu_result    = '0;
    alu_predicate = 1'b0;
    case (alu_out_ctrl)
      3'b000: alu_result = alu_addsub ? alu_a - stub_b : alu_a + stub_b;
      3'b001: alu_result = (alu_addsub ? alu_a - stub_b : alu_a + stub_b) ^ 32'h8000_0000;
      3'b010: alu_result = alu_a * stub_b;
      3'b011: alu_result = alu_a * stub_b + 32'd1;
      3'b100: case (alu_bitwise)
                2'd0: alu_result = alu_a & stub_b;
                2'd1: alu_result = alu_a | stub_b;
                2'd2: alu_result = alu_a ^ stub_b;
                default: alu_result = ~alu_a;
              endcase
      default: ;
    endcase
    case (alu_comp)
      4'd0: alu_predicate = (alu_a == stub_b);
      4'd1: alu_predicate = (alu_a != stub_b);
      4'd2: alu_predicate = (alu_a <  stub_b);
      4'd3: alu_predicate = (alu_a >= stub_b);
      default: ;
    endcase
  end

  // Reference results keyed on the opcode, independent of the control decode.
  function automatic logic [WIDTH-1:0] ref_alu(input logic [3:0] op, input logic [WIDTH-1:0] a, b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_FADD: return (a + b) ^ 32'h8000_0000;
      OP_FSUB: return (a - b) ^ 32'h8000_0000;
      OP_MUL:  return a * b;
      OP_FMUL: return a * b + 32'd1;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NOT:  return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic logic ref_pred(input logic [3:0] cmp, input logic [WIDTH-1:0] a, b);
    case (cmp)
      CMP_EQ:  return a == b;
      CMP_NE:  return a != b;
      CMP_LT:  return a < b;
      CMP_GE:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    int               cyc;
    int               addr;
    logic [WIDTH-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  wr_t mk_q[$];
  int  done_q[$];
  int  rd_q[$];
  int  cyc = 0;
  int  c0  = 0;
  logic mux_seen;
  wr_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rf_wr_en) begin
      mon_e = '{cyc - c0, int'(rf_wr_addr), rf_wr_data};
      wr_q.push_back(mon_e);
    end
    if (mask_wr_en) begin
      mon_e = '{cyc - c0, int'(mask_wr_idx), WIDTH'(mask_wr_data)};
      mk_q.push_back(mon_e);
    end
    if (done)     done_q.push_back(cyc - c0);
    if (rf_rd_en) rd_q.push_back(cyc - c0);
    if (cyc - c0 == 2) mux_seen = alu_mux;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  cmp;
    int          vd, vs1, vs2;
    bit          use_sc;
    logic [31:0] scalar;
    int          vl;
    bit          masked;
    logic [31:0] mask;
    int          exp_rf;
    int          exp_mk;
    int          exp_done;
    logic [31:0] exp_first;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] op, cmp, input int vd, vs1, vs2,
                              input bit use_sc, input logic [31:0] sc, input int vl,
                              input bit masked, input logic [31:0] mask,
                              input int erf, emk, edn, input logic [31:0] first);
    vec_t v;
    v = '{op, cmp, vd, vs1, vs2, use_sc, sc, vl, masked, mask, erf, emk, edn, first};
    return v;
  endfunction

  task automatic clear_mon();
    wr_q.delete(); mk_q.delete(); done_q.delete(); rd_q.delete();
    mux_seen = 1'b0;
  endtask

  task automatic drive_req(input vec_t v);
    req_op         = v.op;
    req_cmp        = v.cmp;
    req_vd         = RW'(v.vd);
    req_vs1        = RW'(v.vs1);
    req_vs2        = RW'(v.vs2);
    req_use_scalar = v.use_sc;
    req_scalar     = v.scalar;
    req_vl         = VLW'(v.vl);
    req_masked     = v.masked;
    req_mask       = v.mask;
  endtask

  task automatic start_req(input vec_t v, input string tag);
    @(posedge clk); #1;
    clear_mon();
    c0 = cyc;
    check({tag, "_rdy_before"}, 64'(req_rdy), 64'd1);
    drive_req(v);
    req_val = 1'b1;
    @(posedge clk); #1;
    req_val = 1'b0;
  endtask

  task automatic wait_done(input int n, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_q.size() >= n) begin ok = 1'b1; break; end
    end
    check({tag, "_done_seen"}, 64'(ok), 64'd1);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    wr_t exp_wr[$];
    wr_t exp_mk[$];
    wr_t e;
    int  vle;
    logic [WIDTH-1:0] a, b;
    vle = (v.vl > VLMAX) ? VLMAX : v.vl;
    for (int i = 0; i < vle; i++) begin
      a = init_val(v.vs1, i);
      b = v.use_sc ? v.scalar : init_val(v.vs2, i);
      if (v.masked && !v.mask[i]) continue;
      if (v.op == OP_CMP) begin
        e = '{3 + i, i, WIDTH'(ref_pred(v.cmp, a, b))};
        exp_mk.push_back(e);
      end else if (v.op < OP_CMP) begin
        e = '{3 + i, v.vd * VLMAX + i, ref_alu(v.op, a, b)};
        exp_wr.push_back(e);
      end
    end
    start_req(v, tag);
    wait_done(1, vle + 40, tag);
    check({tag, "_done_count"}, 64'(done_q.size()), 64'd1);
    if (done_q.size() > 0) check({tag, "_done_cycle"}, 64'(done_q[0]), 64'(v.exp_done));
    check({tag, "_rf_wr_count"}, 64'(wr_q.size()), 64'(v.exp_rf));
    check({tag, "_mask_wr_count"}, 64'(mk_q.size()), 64'(v.exp_mk));
    check({tag, "_rd_count"}, 64'(rd_q.size()), 64'(vle));
    if (vle > 0 && rd_q.size() > 0) check({tag, "_first_rd_cycle"}, 64'(rd_q[0]), 64'd1);
    if (v.exp_rf > 0 && wr_q.size() > 0) check({tag, "_first_data"}, 64'(wr_q[0].data), 64'(v.exp_first));
    if (v.exp_mk > 0 && mk_q.size() > 0) check({tag, "_first_pred"}, 64'(mk_q[0].data), 64'(v.exp_first));
    if (v.use_sc) check({tag, "_alu_mux"}, 64'(mux_seen), 64'd1);
    for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
      check($sformatf("%s_wr%0d_cyc", tag, i),  64'(wr_q[i].cyc),  64'(exp_wr[i].cyc));
      check($sformatf("%s_wr%0d_addr", tag, i), 64'(wr_q[i].addr), 64'(exp_wr[i].addr));
      check($sformatf("%s_wr%0d_data", tag, i), 64'(wr_q[i].data), 64'(exp_wr[i].data));
    end
    for (int i = 0; i < exp_mk.size() && i < mk_q.size(); i++) begin
      check($sformatf("%s_mk%0d_cyc", tag, i),  64'(mk_q[i].cyc),  64'(exp_mk[i].cyc));
      check($sformatf("%s_mk%0d_idx", tag, i),  64'(mk_q[i].addr), 64'(exp_mk[i].addr));
      check($sformatf("%s_mk%0d_pred", tag, i), 64'(mk_q[i].data), 64'(exp_mk[i].data));
    end
    #1;
    check({tag, "_quiet"},
          64'({req_rdy, rf_wr_en, mask_wr_en, done, rf_rd_en, |alu_a, |alu_c, |rf_rd_addr_a}),
          64'(8'b1000_0000));
  endtask

  vec_t tbl[15];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //                op       cmp     vd vs1 vs2 sc  scalar        vl  msk mask     rf mk dn first
    tbl[0]  = mk(OP_ADD,  CMP_EQ,  8, 1, 2, 0, 32'd0,       4,  0, 32'h0,   4, 0, 7,  32'd11);
    tbl[1]  = mk(OP_SUB,  CMP_EQ,  9, 3, 2, 1, 32'd5,       2,  0, 32'h0,   2, 0, 5,  32'd2);
    tbl[2]  = mk(OP_CMP,  CMP_LT,  7, 4, 5, 0, 32'd0,       3,  1, 32'h5,   0, 2, 6,  32'd1);
    tbl[3]  = mk(OP_ADD,  CMP_EQ,  8, 1, 2, 0, 32'd0,       0,  0, 32'h0,   0, 0, 1,  32'd0);
    tbl[4]  = mk(OP_ADD,  CMP_EQ, 11, 1, 2, 0, 32'd0,  VLMAX+5, 0, 32'h0,  32, 0, 35, 32'd11);
    tbl[5]  = mk(OP_MUL,  CMP_EQ, 12, 1, 2, 0, 32'd0,       3,  0, 32'h0,   3, 0, 6,  32'd10);
    tbl[6]  = mk(OP_XOR,  CMP_EQ, 13, 1, 2, 0, 32'd0,       4,  1, 32'h6,   2, 0, 7,  32'd22);
    tbl[7]  = mk(4'd12,   CMP_EQ, 13, 1, 2, 0, 32'd0,       3,  0, 32'h0,   0, 0, 6,  32'd0);
    tbl[8]  = mk(OP_FSUB, CMP_EQ, 14, 2, 1, 0, 32'd0,       2,  0, 32'h0,   2, 0, 5,  32'h8000_0009);
    tbl[9]  = mk(OP_NOT,  CMP_EQ, 15, 5, 2, 0, 32'd0,       1,  0, 32'h0,   1, 0, 4,  32'hFFFF_FFFA);
    tbl[10] = mk(OP_AND,  CMP_EQ, 16, 6, 2, 1, 32'h603,     2,  0, 32'h0,   2, 0, 5,  32'h600);
    tbl[11] = mk(OP_CMP,  CMP_EQ,  7, 4, 2, 1, 32'd9,       3,  0, 32'h0,   0, 3, 6,  32'd0);
    tbl[12] = mk(OP_FMUL, CMP_EQ, 17, 1, 2, 0, 32'd0,       2,  0, 32'h0,   2, 0, 5,  32'd11);
    tbl[13] = mk(OP_OR,   CMP_EQ, 18, 1, 2, 0, 32'd0,       1,  0, 32'h0,   1, 0, 4,  32'd11);
    tbl[14] = mk(OP_FADD, CMP_EQ, 19, 1, 2, 0, 32'd0,       1,  0, 32'h0,   1, 0, 4,  32'h8000_000B);

    reset   = 1'b1;
    req_val = 1'b0;
    drive_req(tbl[0]);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_state",
          64'({req_rdy, done, rf_rd_en, rf_wr_en, mask_wr_en, |alu_a, |alu_out_ctrl, |rf_wr_addr}),
          64'(8'b1000_0000));

    for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset in cycle 4 of an 8-element ADD: elements 0 and 1 retire, nothing after.
    begin
      vec_t v;
      int late, early;
      v = mk(OP_ADD, CMP_EQ, 20, 1, 2, 0, 32'd0, 8, 0, 32'h0, 8, 0, 11, 32'd11);
      start_req(v, "rst");
      repeat (3) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("rst_cycle5_outputs", 64'({req_rdy, done, rf_rd_en, rf_wr_en, mask_wr_en}), 64'(5'b10000));
      repeat (6) @(posedge clk);
      late = 0; early = 0;
      foreach (wr_q[i]) if (wr_q[i].cyc >= 5) late++; else early++;
      check("rst_writes_after", 64'(late), 64'd0);
      check("rst_writes_before", 64'(early), 64'd2);
      check("rst_no_done", 64'(done_q.size()), 64'd0);
      run_vec(mk(OP_ADD, CMP_EQ, 21, 1, 2, 0, 32'd0, 1, 0, 32'h0, 1, 0, 4, 32'd11), "post_rst");
    end

    // Back-to-back: req_val held, second accept lands on the first done cycle.
    begin
      int exp_cyc[5]  = '{3, 4, 8, 9, 10};
      int exp_addr[5] = '{22*VLMAX, 22*VLMAX+1, 23*VLMAX, 23*VLMAX+1, 23*VLMAX+2};
      logic [31:0] exp_dat[5] = '{32'd11, 32'd22, 32'd9, 32'd18, 32'd27};
      @(posedge clk); #1;
      clear_mon();
      c0 = cyc;
      drive_req(mk(OP_ADD, CMP_EQ, 22, 1, 2, 0, 32'd0, 2, 0, 32'h0, 0, 0, 0, 32'd0));
      req_val = 1'b1;
      @(posedge clk); #1;
      drive_req(mk(OP_SUB, CMP_EQ, 23, 2, 1, 0, 32'd0, 3, 0, 32'h0, 0, 0, 0, 32'd0));
      repeat (4) @(posedge clk);
      #1;
      check("b2b_cycle5_rdy_done", 64'({req_rdy, done}), 64'(2'b11));
      @(posedge clk); #1;
      req_val = 1'b0;
      wait_done(2, 40, "b2b");
      check("b2b_done_count", 64'(done_q.size()), 64'd2);
      if (done_q.size() >= 2) begin
        check("b2b_done0_cycle", 64'(done_q[0]), 64'd5);
        check("b2b_done1_cycle", 64'(done_q[1]), 64'd11);
      end
      check("b2b_wr_count", 64'(wr_q.size()), 64'd5);
      for (int i = 0; i < 5 && i < wr_q.size(); i++) begin
        check($sformatf("b2b_wr%0d_cyc", i),  64'(wr_q[i].cyc),  64'(exp_cyc[i]));
        check($sformatf("b2b_wr%0d_addr", i), 64'(wr_q[i].addr), 64'(exp_addr[i]));
        check($sformatf("b2b_wr%0d_data", i), 64'(wr_q[i].data), 64'(exp_dat[i]));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
